// File: rtl/elevator_call_dispatcher_if.sv
// Bundle of the call-button, floor-report and dispatcher-status signals
// exchanged between the call dispatcher and the elevator/button side.
interface elevator_call_dispatcher_if #(
    parameter int NUM_FLOORS = 10
);
    logic [NUM_FLOORS-1:0] call_btn;
    logic [3:0]            current_floor;
    logic [3:0]            target_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  door_open;
    logic                  busy;

    modport master (
        input  call_btn,
        input  current_floor,
        output target_floor,
        output pending,
        output dir_up,
        output door_open,
        output busy
    );

    modport slave (
        output call_btn,
        output current_floor,
        input  target_floor,
        input  pending,
        input  dir_up,
        input  door_open,
        input  busy
    );
endinterface

// File: rtl/elevator_call_dispatcher.sv
// Elevator call dispatcher: latches call-button presses into a pending mask,
// picks the next target floor with a SCAN (keep-direction) policy and holds
// the door open for a dwell period on every arrival.
module elevator_call_dispatcher #(
    parameter int          NUM_FLOORS  = 10,
    parameter logic [31:0] DWELL_COUNT = 32'd5000000
) (
    input logic                  clk,
    input logic                  reset,
    elevator_call_dispatcher_if.master bus
);

    localparam logic [31:0] DWELL_LAST = DWELL_COUNT - 32'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            target_floor_q, target_floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  dir_up_q, dir_up_d;
    logic                  door_open_q, door_open_d;
    logic [31:0]           counter_q, counter_d;
    logic [NUM_FLOORS-1:0] btn_q;

    logic [3:0]            cur;
    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] cur_onehot;
    logic [NUM_FLOORS-1:0] clr;
    logic                  press_at_cur;
    logic                  mask_cur;
    logic                  up_found, dn_found, sel_found;
    logic [3:0]            up_idx, dn_idx, sel_idx;

    assign cur   = bus.current_floor;
    assign press = bus.call_btn & ~btn_q;

    // Nearest pending floor at/above and at/below the current floor, plus the SCAN choice
    always_comb begin
        up_found   = 1'b0;
        up_idx     = 4'd0;
        dn_found   = 1'b0;
        dn_idx     = 4'd0;
        cur_onehot = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (4'(i) >= cur)) begin
                up_found = 1'b1;
                up_idx   = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (4'(i) <= cur)) begin
                dn_found = 1'b1;
                dn_idx   = 4'(i);
            end
            cur_onehot[i] = (cur == 4'(i));
        end
        sel_found    = up_found | dn_found;
        if (dir_up_q) begin
            sel_idx = up_found ? up_idx : dn_idx;
        end else begin
            sel_idx = dn_found ? dn_idx : up_idx;
        end
        press_at_cur = |(press & cur_onehot);
    end

    // Next-state, target, direction, door and dwell-counter decisions
    always_comb begin
        state_d        = state_q;
        target_floor_d = target_floor_q;
        dir_up_d       = dir_up_q;
        door_open_d    = door_open_q;
        counter_d      = counter_q;
        clr            = '0;
        mask_cur       = 1'b0;
        case (state_q)
            IDLE: begin
                target_floor_d = cur;
                counter_d      = 32'd0;
                if ((|pending_q) && sel_found) begin
                    if (sel_idx == cur) begin
                        clr         = cur_onehot;
                        mask_cur    = 1'b1;
                        door_open_d = 1'b1;
                        state_d     = DWELL;
                    end else begin
                        target_floor_d = sel_idx;
                        dir_up_d       = (sel_idx > cur);
                        state_d        = SERVE;
                    end
                end
            end
            SERVE: begin
                if (target_floor_q == cur) begin
                    clr         = cur_onehot;
                    door_open_d = 1'b1;
                    counter_d   = 32'd0;
                    state_d     = DWELL;
                end else if (dir_up_q && up_found) begin
                    target_floor_d = up_idx;
                end else if (!dir_up_q && dn_found) begin
                    target_floor_d = dn_idx;
                end
            end
            DWELL: begin
                mask_cur = 1'b1;
                if (press_at_cur) begin
                    counter_d = 32'd0;
                end else if (counter_q == DWELL_LAST) begin
                    door_open_d = 1'b0;
                    counter_d   = 32'd0;
                    state_d     = IDLE;
                end else begin
                    counter_d = counter_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pending_d = (pending_q | (press & ~(mask_cur ? cur_onehot : '0))) & ~clr;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            target_floor_q <= 4'd0;
            pending_q      <= '0;
            dir_up_q       <= 1'b1;
            door_open_q    <= 1'b0;
            counter_q      <= 32'd0;
            btn_q          <= '0;
        end else begin
            state_q        <= state_d;
            target_floor_q <= target_floor_d;
            pending_q      <= pending_d;
            dir_up_q       <= dir_up_d;
            door_open_q    <= door_open_d;
            counter_q      <= counter_d;
            btn_q          <= bus.call_btn;
        end
    end

    assign bus.target_floor = target_floor_q;
    assign bus.pending      = pending_q;
    assign bus.dir_up       = dir_up_q;
    assign bus.door_open    = door_open_q;
    assign bus.busy         = (state_q != IDLE) || (|pending_q);

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed testbench for the elevator call dispatcher (dwell of 4 cycles).
module tb_elevator_call_dispatcher;

    localparam int NF = 10;

    logic clk;
    logic reset;
    int   check_count = 0;
    int   pass_count  = 0;
    int   fail_count  = 0;
    int   door_cnt;
    logic late_bit6;

    elevator_call_dispatcher_if #(.NUM_FLOORS(NF)) bus ();

    elevator_call_dispatcher #(
        .NUM_FLOORS (NF),
        .DWELL_COUNT(32'd4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a runaway simulation
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [NF-1:0] btn, input logic [3:0] floor);
        bus.call_btn      = btn;
        bus.current_floor = floor;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_target"}, 32'(bus.target_floor), 32'h0);
        checkOutput({tag, "_pending"}, 32'(bus.pending), 32'h0);
        checkOutput({tag, "_door"}, 32'(bus.door_open), 32'h0);
        checkOutput({tag, "_dir_up"}, 32'(bus.dir_up), 32'h1);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        // Power-on reset
        reset = 1'b1;
        applyStimulus('0, 4'd0);
        tick(2);
        checkResetValues("reset");
        reset = 1'b0;
        tick(1);

        // Single call to floor 3 from floor 0
        applyStimulus(10'h008, 4'd0);
        tick(1);
        checkOutput("single_pending", 32'(bus.pending), 32'h008);
        checkOutput("single_target_idle", 32'(bus.target_floor), 32'd0);
        checkOutput("single_busy", 32'(bus.busy), 32'h1);
        applyStimulus('0, 4'd0);
        tick(1);
        checkOutput("single_target", 32'(bus.target_floor), 32'd3);
        checkOutput("single_dir_up", 32'(bus.dir_up), 32'h1);
        tick(1);
        applyStimulus('0, 4'd3);
        tick(1);
        checkOutput("single_arrive_pending", 32'(bus.pending), 32'h0);
        checkOutput("single_arrive_target", 32'(bus.target_floor), 32'd3);
        for (int i = 0; i < 4; i++) begin
            checkOutput("single_door_high", 32'(bus.door_open), 32'h1);
            tick(1);
        end
        checkOutput("single_door_low", 32'(bus.door_open), 32'h0);
        checkOutput("single_idle_target", 32'(bus.target_floor), 32'd3);
        checkOutput("single_idle_busy", 32'(bus.busy), 32'h0);

        // Pickup en route: call 7 from 0, then floor 4 pre-empts at floor 2
        applyStimulus('0, 4'd0);
        tick(1);
        applyStimulus(10'h080, 4'd0);
        tick(1);
        checkOutput("pickup_pending7", 32'(bus.pending), 32'h080);
        applyStimulus('0, 4'd0);
        tick(1);
        checkOutput("pickup_target7", 32'(bus.target_floor), 32'd7);
        checkOutput("pickup_dir_up", 32'(bus.dir_up), 32'h1);
        applyStimulus('0, 4'd2);
        tick(1);
        checkOutput("pickup_hold7", 32'(bus.target_floor), 32'd7);
        applyStimulus(10'h010, 4'd2);
        tick(1);
        checkOutput("pickup_pending47", 32'(bus.pending), 32'h090);
        checkOutput("pickup_still7", 32'(bus.target_floor), 32'd7);
        applyStimulus('0, 4'd2);
        tick(1);
        checkOutput("pickup_target4", 32'(bus.target_floor), 32'd4);
        applyStimulus('0, 4'd4);
        tick(1);
        checkOutput("pickup_arrive_pending", 32'(bus.pending), 32'h080);
        checkOutput("pickup_arrive_door", 32'(bus.door_open), 32'h1);
        tick(4);
        checkOutput("pickup_dwell_done", 32'(bus.door_open), 32'h0);
        checkOutput("pickup_dwell_target", 32'(bus.target_floor), 32'd4);
        tick(1);
        checkOutput("pickup_resume7", 32'(bus.target_floor), 32'd7);
        applyStimulus('0, 4'd7);
        tick(6);
        checkOutput("pickup_final_busy", 32'(bus.busy), 32'h0);
        checkOutput("pickup_final_target", 32'(bus.target_floor), 32'd7);

        // Reversal: at floor 5 heading up with calls at 2 and 8
        applyStimulus(10'h104, 4'd5);
        tick(1);
        checkOutput("rev_pending", 32'(bus.pending), 32'h104);
        checkOutput("rev_idle_target", 32'(bus.target_floor), 32'd5);
        applyStimulus('0, 4'd5);
        tick(1);
        checkOutput("rev_target8", 32'(bus.target_floor), 32'd8);
        checkOutput("rev_dir_up", 32'(bus.dir_up), 32'h1);
        applyStimulus('0, 4'd8);
        tick(1);
        checkOutput("rev_arrive_pending", 32'(bus.pending), 32'h004);
        checkOutput("rev_arrive_door", 32'(bus.door_open), 32'h1);
        tick(4);
        checkOutput("rev_dwell_done", 32'(bus.door_open), 32'h0);
        tick(1);
        checkOutput("rev_target2", 32'(bus.target_floor), 32'd2);
        checkOutput("rev_dir_down", 32'(bus.dir_up), 32'h0);
        applyStimulus('0, 4'd2);
        tick(6);
        checkOutput("rev_final_busy", 32'(bus.busy), 32'h0);
        checkOutput("rev_final_dir", 32'(bus.dir_up), 32'h0);

        // Call held at the current floor for 20 cycles: a single dwell
        applyStimulus('0, 4'd6);
        tick(1);
        checkOutput("here_idle_target", 32'(bus.target_floor), 32'd6);
        applyStimulus(10'h040, 4'd6);
        door_cnt  = 0;
        late_bit6 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.door_open) door_cnt++;
            if (i >= 1 && bus.pending[6]) late_bit6 = 1'b1;
        end
        checkOutput("here_door_cycles", 32'(door_cnt), 32'd4);
        checkOutput("here_bit6_retained", 32'(late_bit6), 32'h0);
        checkOutput("here_busy", 32'(bus.busy), 32'h0);
        applyStimulus('0, 4'd6);
        tick(1);

        // Press at 3 on the arrival cycle, then again during dwell
        applyStimulus(10'h008, 4'd6);
        tick(1);
        checkOutput("sim_pending3", 32'(bus.pending), 32'h008);
        applyStimulus('0, 4'd6);
        tick(1);
        checkOutput("sim_target3", 32'(bus.target_floor), 32'd3);
        checkOutput("sim_dir_down", 32'(bus.dir_up), 32'h0);
        applyStimulus(10'h008, 4'd3);
        tick(1);
        checkOutput("sim_clear_wins", 32'(bus.pending), 32'h0);
        checkOutput("sim_door_open", 32'(bus.door_open), 32'h1);
        door_cnt = 1;
        applyStimulus('0, 4'd3);
        tick(1);
        if (bus.door_open) door_cnt++;
        applyStimulus(10'h008, 4'd3);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus.door_open) door_cnt++;
        end
        checkOutput("sim_door_extended", 32'(door_cnt), 32'd6);
        checkOutput("sim_door_closed", 32'(bus.door_open), 32'h0);
        checkOutput("sim_no_pending", 32'(bus.pending), 32'h0);
        applyStimulus('0, 4'd3);
        tick(1);

        // Reset asserted mid-SERVE toward floor 7
        applyStimulus(10'h080, 4'd3);
        tick(1);
        applyStimulus('0, 4'd3);
        tick(1);
        checkOutput("rst_serve_target", 32'(bus.target_floor), 32'd7);
        checkOutput("rst_serve_busy", 32'(bus.busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkResetValues("rst_mid");
        tick(1);
        reset = 1'b0;
        tick(1);

        // Current floor beyond the served range
        applyStimulus('0, 4'd12);
        tick(1);
        checkOutput("oor_idle_target", 32'(bus.target_floor), 32'd12);
        applyStimulus(10'h200, 4'd12);
        tick(1);
        checkOutput("oor_pending9", 32'(bus.pending), 32'h200);
        applyStimulus('0, 4'd12);
        tick(1);
        checkOutput("oor_target9", 32'(bus.target_floor), 32'd9);
        checkOutput("oor_dir_down", 32'(bus.dir_up), 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/elevator_call_dispatcher.md
Name: elevator_call_dispatcher

Overview:
- Request source for the elevator state machine. It produces the target floor that the elevator consumes, and it reads back the elevator's current floor.
- Latches hall/car call-button presses into a pending-request mask and selects the next target floor with a SCAN (keep-direction) policy.
- Holds the door open for a dwell period on each arrival. During idle and dwell it parks the target at the current floor so the elevator stays put.

Parameters:
- NUM_FLOORS, 10, number of served floors (max 16); valid floor indices are 0..NUM_FLOORS-1.
- DWELL_COUNT, 32'd5000000, number of cycles door_open stays high per arrival; benches use 4.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- call_btn  input  NUM_FLOORS  level button inputs, already synchronous to clk; bit i = call for floor i
- current_floor  input  4  floor reported by the elevator
- target_floor  output  4  registered floor request to the elevator
- pending  output  NUM_FLOORS  registered outstanding-call mask
- dir_up  output  1  registered travel direction; 1 = up
- door_open  output  1  registered; high during dwell
- busy  output  1  high when state != IDLE or pending != 0

Behaviour:
- Reset values:
  - Every output is 0 except dir_up = 1.
  - State = IDLE; dwell counter = 0; button history register = 0.
  - Reset asserted in any state, including mid-SERVE or mid-DWELL, aborts the operation immediately.
- Press detection:
  - press[i] = call_btn[i] & ~btn_q[i], where btn_q is call_btn registered every cycle.
  - A held button registers exactly once.
  - A press in cycle N is visible in pending at N+1.
- Pending update, every cycle: pending <= (pending | press_eff) & ~clr.
  - clr is the one-hot of target_floor on an arrival cycle; clear wins over a simultaneous press.
  - press_eff masks press[current_floor] while state is DWELL, or while state is IDLE and the selection picks current_floor.
- Selection function, combinational, from current_floor c and dir_up:
  - up_hit = lowest pending floor >= c.
  - dn_hit = highest pending floor <= c.
  - If dir_up: use up_hit if it exists, else dn_hit. Otherwise use dn_hit if it exists, else up_hit.
  - Selection consumes the registered pending, not the same-cycle press.
- States:
  - IDLE:
    - target_floor <= c.
    - If pending != 0, evaluate the selection s. If s == c: clear pending[c], door_open <= 1, go to DWELL. Else: target_floor <= s, dir_up <= (s > c), go to SERVE.
  - SERVE:
    - If target_floor == c: arrival. Clear pending[c], door_open <= 1, counter <= 0, go to DWELL; target_floor holds.
    - Else: target_floor <= nearest pending floor in the dir_up direction, inclusive of c. This lets intermediate calls pre-empt the target. dir_up is unchanged.
  - DWELL:
    - counter increments each cycle.
    - When counter == DWELL_COUNT-1: door_open <= 0, counter <= 0, go to IDLE.
    - door_open is high for exactly DWELL_COUNT cycles.
    - A rising press on c during DWELL restarts the counter at 0 and does not set pending.
    - target_floor holds = c.
- Out-of-range inputs:
  - current_floor >= NUM_FLOORS: no hit matches c; selection treats c as the limit.
  - Button bits above NUM_FLOORS do not exist.
- Widths: comparisons are unsigned, 4-bit; counter is 32-bit.

Test Plan:
- Reset → target_floor=0, pending=0, door_open=0, dir_up=1, busy=0. Then assert reset mid-SERVE (target=7) → all outputs return to the reset values on the same edge.
- Single call: c=0, pulse call_btn[3] → pending=0x008 at the next edge and target_floor=3, dir_up=1 one edge later. Drive c=3 → pending=0, door_open high exactly 4 cycles, then IDLE with target=3.
- Pickup en route: c=0, call 7 → target 7. At c=2, press 4 → target becomes 4. Arrive at 4 → dwell, then target=7.
- Reversal: c=5, dir_up=1, pending={2,8} → target 8. After arrival and dwell → target=2, dir_up=0.
- Call at current floor: IDLE, c=6, hold call_btn[6] for 20 cycles → DWELL immediately, pending bit 6 never retained, single dwell of 4 cycles.
- Simultaneous press and clear: press floor 3 on the arrival cycle at 3 → pending[3]=0 afterwards. Press 3 again during DWELL → counter restarts and door_open is extended.
